// File: rtl/uart_aes_pkg.sv
// Shared definitions for the UART block receiver feeding the AES datapath:
// block geometry, default bit timing and the byte-receiver state encoding.
package uart_aes_pkg;

   localparam int BLOCK_BYTES      = 16;
   localparam int BLOCK_W          = 128;
   localparam int CLKS_PER_BIT_DEF = 868;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   // Width of a counter that must hold the values 0 .. n-1.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop input synchronizer, start-bit glitch rejection,
// 8N1 mid-bit sampling, LSB first. o_byte_valid is a strobe on the stop-bit
// sample cycle (o_byte is stable then); o_frame_err is a registered pulse.
module uart_rx_byte
   import uart_aes_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic       o_byte_valid,
   output logic       o_frame_err,
   output logic [7:0] o_byte,
   output logic       o_idle
);

   localparam int                CNT_W   = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]       r_sync;
   rx_state_e        r_state;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_frame_err;

   rx_state_e        w_state_nxt;
   logic [CNT_W-1:0] w_clk_cnt_nxt;
   logic [2:0]       w_bit_cnt_nxt;
   logic [7:0]       w_shift_nxt;
   logic             w_frame_err_nxt;
   logic             w_byte_valid;
   logic             w_rx;

   assign w_rx = r_sync[1];

   // Bring the asynchronous serial line into the clock domain (idles high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_rx};
      end
   end

   // State, timing counters, data shift register and error pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_clk_cnt   <= '0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_clk_cnt   <= w_clk_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   // Next-state logic: half-bit to the start-bit centre, then full bit periods.
   always_comb begin
      w_state_nxt     = r_state;
      w_clk_cnt_nxt   = r_clk_cnt;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_frame_err_nxt = 1'b0;
      w_byte_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            w_clk_cnt_nxt = '0;
            if (!w_rx) begin
               w_state_nxt = START;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         START: begin
            if (r_clk_cnt == HALF_M1) begin
               w_clk_cnt_nxt = '0;
               w_bit_cnt_nxt = 3'd0;
               if (!w_rx) begin
                  w_state_nxt = DATA;
               end else begin
                  w_state_nxt = IDLE;   // line went high again: a glitch
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (r_clk_cnt == FULL_M1) begin
               w_clk_cnt_nxt = '0;
               w_shift_nxt   = {w_rx, r_shift[7:1]};
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (r_clk_cnt == FULL_M1) begin
               w_clk_cnt_nxt = '0;
               w_state_nxt   = IDLE;
               if (w_rx) begin
                  w_byte_valid = 1'b1;
               end else begin
                  w_frame_err_nxt = 1'b1;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = 3'd0;
         end
      endcase
   end

   assign o_byte_valid = w_byte_valid;
   assign o_frame_err  = r_frame_err;
   assign o_byte       = r_shift;
   assign o_idle       = (r_state == IDLE);

endmodule

// File: rtl/uart_block_rx.sv
// UART block receiver: packs 16 accepted bytes big-endian into a 128-bit
// block and pulses block_valid once per complete block.
// Optional feature macro RX_TIMEOUT_EN: drop a partial block after
// TIMEOUT_BITS idle bit-times.
module uart_block_rx
   import uart_aes_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int TIMEOUT_BITS = 160
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               data_in,
   output logic               block_valid,
   output logic [BLOCK_W-1:0] block_data,
   output logic               frame_err
);

   localparam int PART_W = (BLOCK_BYTES - 1) * 8;

   logic               w_byte_valid;
   logic [7:0]         w_byte;
   logic               w_idle;
   logic               w_timeout;

   logic [3:0]         r_byte_cnt;
   logic [PART_W-1:0]  r_shift;
   logic [BLOCK_W-1:0] r_block_data;
   logic               r_block_valid;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_byte (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rx         (data_in),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (frame_err),
      .o_byte       (w_byte),
      .o_idle       (w_idle)
   );

`ifdef RX_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

   logic [31:0] r_idle_cnt;

   assign w_timeout = w_idle && (r_byte_cnt != 4'd0) && (r_idle_cnt == TO_LAST);

   // Count idle-line clocks only while a partial block is pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= 32'd0;
      end else if (!w_idle || (r_byte_cnt == 4'd0) || w_timeout) begin
         r_idle_cnt <= 32'd0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 32'd1;
      end
   end
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = w_idle ^ (TIMEOUT_BITS == 0);
`endif

   // Pack accepted bytes; the 16th completes the block and clears the packer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_cnt    <= 4'd0;
         r_shift       <= '0;
         r_block_data  <= '0;
         r_block_valid <= 1'b0;
      end else begin
         r_block_valid <= 1'b0;
         if (w_byte_valid) begin
            if (r_byte_cnt == 4'd15) begin
               r_block_data  <= {r_shift, w_byte};
               r_block_valid <= 1'b1;
               r_byte_cnt    <= 4'd0;
               r_shift       <= '0;
            end else begin
               r_shift    <= {r_shift[PART_W-9:0], w_byte};
               r_byte_cnt <= r_byte_cnt + 4'd1;
            end
         end else if (w_timeout) begin
            r_byte_cnt <= 4'd0;
            r_shift    <= '0;
         end else begin
            r_byte_cnt <= r_byte_cnt;
         end
      end
   end

   assign block_valid = r_block_valid;
   assign block_data  = r_block_data;

endmodule

// File: tb/tb_uart_block_rx.sv
// Directed, table-driven bench for uart_block_rx with 16 clocks per bit.
module tb_uart_block_rx;

   logic         clk;
   logic         rst_n;
   logic         data_in;
   logic         block_valid;
   logic [127:0] block_data;
   logic         frame_err;

   uart_block_rx #(
      .CLKS_PER_BIT (16),
      .TIMEOUT_BITS (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .block_valid (block_valid),
      .block_data  (block_data),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor, sampled on the falling edge.
   int           mon_v;
   int           mon_fe;
   logic [127:0] mon_blk[$];
   initial begin
      mon_v  = 0;
      mon_fe = 0;
   end
   always @(negedge clk) begin
      if (block_valid) begin
         mon_v = mon_v + 1;
         mon_blk.push_back(block_data);
      end
      if (frame_err) mon_fe = mon_fe + 1;
   end

   int n_pass;
   int n_total;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stp);
      data_in = 1'b0;
      wait_clks(16);
      for (int i = 0; i < 8; i++) begin
         data_in = b[i];
         wait_clks(16);
      end
      data_in = stp;
      wait_clks(16);
      if (!stp) begin
         data_in = 1'b1;
         wait_clks(32);
      end
   endtask

   typedef struct {
      string             name;
      int                nfr;
      logic [16:0][7:0]  fr;
      logic [16:0]       stp;
      logic [127:0]      exp_blk;
      int                exp_v;
      int                exp_fe;
   } vec_t;

   vec_t vecs[3];
   int   v0;
   int   fe0;
   int   q0;

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      data_in = 1'b1;

      // Table: 00..FF; frame error on byte 5; descending-nibble pattern.
      vecs[0].name = "blk_00_ff";
      vecs[0].nfr  = 16;
      vecs[0].stp  = '1;
      for (int i = 0; i < 16; i++) vecs[0].fr[i] = 8'(i * 17);
      vecs[0].exp_blk = 128'h00112233445566778899AABBCCDDEEFF;
      vecs[0].exp_v   = 1;
      vecs[0].exp_fe  = 0;

      vecs[1].name = "blk_ferr";
      vecs[1].nfr  = 17;
      vecs[1].stp  = '1;
      for (int i = 0; i < 4; i++) vecs[1].fr[i] = 8'(i + 1);
      vecs[1].fr[4]  = 8'hEE;
      vecs[1].stp[4] = 1'b0;
      for (int i = 5; i < 17; i++) vecs[1].fr[i] = 8'(i);
      vecs[1].exp_blk = 128'h0102030405060708090A0B0C0D0E0F10;
      vecs[1].exp_v   = 1;
      vecs[1].exp_fe  = 1;

      vecs[2].name = "blk_nib";
      vecs[2].nfr  = 16;
      vecs[2].stp  = '1;
      for (int i = 0; i < 16; i++) vecs[2].fr[i] = 8'(i * 16 + (15 - i));
      vecs[2].exp_blk = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      vecs[2].exp_v   = 1;
      vecs[2].exp_fe  = 0;

      // Reset state.
      wait_clks(3);
      chk("rst_block_valid", 128'(block_valid), 128'd0);
      chk("rst_frame_err",   128'(frame_err),   128'd0);
      chk("rst_block_data",  block_data,        128'd0);
      rst_n = 1'b1;
      wait_clks(5);

      // Table-driven vectors.
      for (int k = 0; k < 3; k++) begin
         v0  = mon_v;
         fe0 = mon_fe;
         for (int i = 0; i < vecs[k].nfr; i++) send_byte(vecs[k].fr[i], vecs[k].stp[i]);
         wait_clks(4);
         chk({vecs[k].name, "_valid_cnt"}, 128'(mon_v - v0),   128'(vecs[k].exp_v));
         chk({vecs[k].name, "_ferr_cnt"},  128'(mon_fe - fe0), 128'(vecs[k].exp_fe));
         chk({vecs[k].name, "_data"},      block_data,         vecs[k].exp_blk);
      end

      // Short low glitch in IDLE must be rejected without touching the count.
      v0  = mon_v;
      fe0 = mon_fe;
      data_in = 1'b0;
      wait_clks(4);
      data_in = 1'b1;
      wait_clks(40);
      chk("glitch_no_valid", 128'(mon_v - v0),   128'd0);
      chk("glitch_no_ferr",  128'(mon_fe - fe0), 128'd0);
      for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b1);
      wait_clks(4);
      chk("glitch_then_valid", 128'(mon_v - v0), 128'd1);
      chk("glitch_then_data",  block_data,       128'h00112233445566778899AABBCCDDEEFF);

      // Reset midway through byte 9 discards the partial block.
      for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b1);
      data_in = 1'b0;
      wait_clks(16);
      data_in = 1'b1;
      wait_clks(40);
      rst_n = 1'b0;
      wait_clks(2);
      chk("midrst_block_data",  block_data,        128'd0);
      chk("midrst_block_valid", 128'(block_valid), 128'd0);
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(20);
      v0 = mon_v;
      for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i), 1'b1);
      wait_clks(4);
      chk("midrst_valid_cnt", 128'(mon_v - v0), 128'd1);
      chk("midrst_data",      block_data,       128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

      // Two blocks back-to-back with no inter-frame gap.
      v0 = mon_v;
      q0 = mon_blk.size();
      for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i), 1'b1);
      for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i), 1'b1);
      wait_clks(4);
      chk("b2b_valid_cnt", 128'(mon_v - v0), 128'd2);
      if (mon_blk.size() >= q0 + 2) begin
         chk("b2b_blk0", mon_blk[q0],     128'h303132333435363738393A3B3C3D3E3F);
         chk("b2b_blk1", mon_blk[q0 + 1], 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
      end else begin
         chk("b2b_blk_count", 128'(mon_blk.size() - q0), 128'd2);
      end

`ifdef RX_TIMEOUT_EN
      // Partial block of 3 bytes is dropped after an 80-clock idle line.
      v0 = mon_v;
      for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 1'b1);
      wait_clks(80);
      for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b1);
      wait_clks(4);
      chk("timeout_valid_cnt", 128'(mon_v - v0), 128'd1);
      chk("timeout_data",      block_data,       128'h0102030405060708090A0B0C0D0E0F10);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_block_rx.md
UART_BLOCK_RX -- requirements
Module: uart_block_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter TIMEOUT_BITS, default 160, idle bit-times before a partial block is discarded (used only under RX_TIMEOUT_EN).
REQ-003 Port clk, input, 1, single system clock, rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 Port data_in, input, 1, asynchronous UART serial line, idle high.
REQ-006 Port block_valid, output, 1, one-cycle pulse when a full 128-bit block is available; feeds the encryption stage's data-state strobe.
REQ-007 Port block_data, output, 128, assembled block; held stable until the next block_valid.
REQ-008 Port frame_err, output, 1, one-cycle pulse on a bad stop bit.

Function
REQ-009 data_in SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-010 The byte FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-011 IDLE->START SHALL occur on a synchronized low; START SHALL re-sample at CLKS_PER_BIT/2 and go to DATA if the line is low, or back to IDLE if it is high (glitch rejection).
REQ-012 DATA SHALL sample 8 bits LSB-first, one every CLKS_PER_BIT clocks, at mid-bit.
REQ-013 STOP SHALL sample at mid-bit; high means the byte is accepted, low means the byte is discarded and frame_err pulses; either way the FSM returns to IDLE at that sample.
REQ-014 Accepted bytes SHALL pack big-endian: the 1st byte goes to [127:120] and the 16th byte to [7:0].
REQ-015 A 4-bit byte counter SHALL increment per accepted byte; on the 16th byte it SHALL wrap to 0.
REQ-016 On the 16th byte, block_data SHALL load the complete block and block_valid SHALL pulse on the cycle after the stop-bit sample.
REQ-017 A frame error SHALL leave the byte counter and the partial shift register unchanged.
REQ-018 Back-to-back frames SHALL be accepted: a start edge arriving on the cycle the FSM returns to IDLE SHALL be detected.
REQ-019 There is no backpressure; the consumer SHALL capture block_data on block_valid, and block_data is only overwritten by the next full block.

Reset
REQ-020 While rst_n=0: FSM=IDLE, counters=0, shift register=0, block_data=0, block_valid=0, frame_err=0.
REQ-021 Reset mid-byte or mid-block SHALL discard all partial data; after release, the next start bit begins byte 0 of a new block.

Configuration
REQ-022 Macro RX_TIMEOUT_EN defined: the idle-line counter SHALL count clocks in IDLE while the byte counter is non-zero. After TIMEOUT_BITS*CLKS_PER_BIT clocks, the byte counter SHALL clear and the partial block is dropped, with no output pulse.
REQ-023 Macro RX_TIMEOUT_EN undefined: no timeout counter SHALL exist, and a partial block SHALL persist indefinitely.

Structure
REQ-024 Shared package uart_aes_pkg SHALL hold BLOCK_BYTES=16, BLOCK_W=128, the default CLKS_PER_BIT, and the rx FSM state encoding.
REQ-025 The design SHALL include one sub-module, uart_rx_byte, covering the synchronizer, byte FSM, byte_valid/frame_err and 8-bit byte out.
REQ-026 The top level SHALL hold the packer, byte counter and timeout logic.

Verification (bench uses CLKS_PER_BIT=16)
REQ-027 Send bytes 00,11,22,...,FF, each with stop=1 -> one block_valid pulse, block_data=128'h00112233445566778899AABBCCDDEEFF, frame_err never asserted.
REQ-028 Drive data_in low for 4 clocks in IDLE, then high -> no byte accepted, counter unchanged, no pulses.
REQ-029 Byte 5 sent with stop=0, then 12 good bytes -> frame_err pulses once; block_valid fires only after the 16th good byte, and byte 5's value is absent from the block.
REQ-030 Assert rst_n low midway through byte 9, release, then send 16 bytes A0..AF -> block_data=128'hA0A1...AF, exactly one block_valid pulse.
REQ-031 With RX_TIMEOUT_EN and TIMEOUT_BITS=4: send 3 bytes, idle 80 clocks, then send 16 bytes 01..10 -> block_data=128'h0102...10.
REQ-032 Two full blocks sent with zero inter-frame gap -> two block_valid pulses, each with the correct block_data.
